writeback_retire: RTL and testbench
===================================

// Module: writeback_retire
// PURPOSE
//  Parametrised writeback/retire stage: selects the register-file and CSR write data for each retiring
//  instruction, prioritises exceptions and interrupts, and issues the trap redirect.
//  After a trap it holds the pipeline in a fixed-length flush window and counts retired instructions.
//  Sits between the MEM stage and the register file, CSR file and fetch PC mux.
// PARAMETERS
//  XLEN          64  datapath width; must be >= 8.
//  ILEN          32  instruction width.
//  FLUSH_CYCLES  2   cycles WB_READY stays low after a trap; legal range 1..15.
//  CNT_W         64  width of the retired-instruction counter.
// PORTS
//  CLK               in   1      clock; all state changes on the rising edge.
//  RESET             in   1      synchronous, active-low reset.
//  WB_V              in   1      an instruction is presented this cycle.
//  WB_READY          out  1      stage accepts; accept = WB_V & WB_READY.
//  WB_IR             in   ILEN   instruction word.
//  WB_NPC            in   XLEN   PC+4 (link value).
//  WB_ALU_RESULT     in   XLEN   ALU result; also the branch/jump target.
//  WB_MEM_RESULT     in   XLEN   load data.
//  WB_RFD            in   XLEN   old CSR value destined for rd (CSR instructions).
//  WB_CSRFD          in   XLEN   new CSR value.
//  WB_PC_MUX         in   1      branch/jump taken.
//  WB_EXC            in   8      {SAF,LAF,SAM,LAM,ECALL,II,IAF,IAM}, bit 0 = IAM.
//  TIMER, EXTERNAL   in   1      interrupt requests, level.
//  PRIVILEGE         in   2      current privilege (0=U,1=S,3=M).
//  TVEC              in   XLEN   trap vector base.
//  WB_RF_DATA        out  XLEN   rd write data.
//  WB_DRID_OUT       out  5      rd index = WB_IR[11:7].
//  WB_ST_REG         out  1      rd write strobe, 1-cycle pulse.
//  WB_CSR_DATA       out  XLEN   CSR write data.
//  WB_ST_CSR         out  1      CSR write strobe, 1-cycle pulse.
//  WB_BR_JMP_TARGET  out  XLEN   redirect target.
//  WB_PC_MUX_OUT     out  1      redirect strobe, 1-cycle pulse.
//  WB_IR_OUT         out  ILEN   registered IR.
//  WB_CAUSE          out  XLEN   trap cause; bit XLEN-1 = interrupt.
//  WB_CS             out  1      trap (context switch) strobe, 1-cycle pulse.
//  WB_FLUSH          out  1      high throughout the flush window.
//  WB_INSTRET        out  CNT_W  retired-instruction count.
// BEHAVIOUR
//  Reset (RESET==0 at the edge): every output 0 except WB_READY=1. FSM goes to RUN and the flush counter
//   clears. Reset overrides everything, including mid-flush.
//  Registered outputs: latency 1 cycle from accept.
//  Cycles with no accept:
//   - strobes ST_REG, ST_CSR, PC_MUX_OUT and CS are 0;
//   - data outputs hold their values.
//  FSM RUN:
//   - WB_READY=1, WB_FLUSH=0.
//   - Trap on accept: FLUSH, counter loaded with FLUSH_CYCLES.
//  FSM FLUSH:
//   - WB_READY=0, WB_FLUSH=1; WB_V is ignored (upstream holds it).
//   - Counter decrements each cycle; at 1 the FSM returns to RUN, so READY is low for exactly FLUSH_CYCLES.
//  Trap priority on accept, highest first:
//   - EXTERNAL: cause {1,..,11}.
//   - TIMER: cause {1,..,7}.
//   - IAM 0, IAF 1, II 2.
//   - ECALL: cause 8+PRIVILEGE (8/9/11).
//   - LAM 4, SAM 6, LAF 5, SAF 7.
//  On trap:
//   - CS=1, CAUSE set, PC_MUX_OUT=1, BR_JMP_TARGET=TVEC.
//   - ST_REG=0, ST_CSR=0; INSTRET unchanged.
//  No trap:
//   - Destination select on opcode WB_IR[6:0]:
//     - 0000011: MEM_RESULT.
//     - 0010011 / 0110011 / 0011011 / 0111011 / 0110111 / 0010111: ALU_RESULT.
//     - 1101111 / 1100111: NPC.
//     - 1110011 with funct3!=0: RF_DATA=RFD, CSR_DATA=CSRFD, ST_CSR=1.
//     - Anything else: no register write.
//   - ST_REG=1 only for the opcodes above and rd!=0.
//   - PC_MUX_OUT=WB_PC_MUX, BR_JMP_TARGET=ALU_RESULT.
//   - INSTRET+1, wrapping modulo 2^CNT_W.
//  Simultaneous interrupt + exception: the interrupt wins; the instruction is not retired.
//  Every accept registers IR_OUT and DRID_OUT.
// TESTING
//  1. Reset low 2 cycles, then high: all outputs 0, READY=1, INSTRET=0.
//  2. ADDI x5 (IR=0x00A28293), ALU=0x1234, V=1: next cycle RF_DATA=0x1234, DRID=5, ST_REG=1, INSTRET=1;
//     ST_REG=0 the cycle after.
//  3. JAL x0 (0x0000006F), NPC=0x104, ALU=0x200, PC_MUX=1: ST_REG=0, PC_MUX_OUT=1, TARGET=0x200.
//  4. ECALL at PRIVILEGE=3, TVEC=0x8000_0000, FLUSH_CYCLES=2: CS=1, CAUSE=11, TARGET=0x8000_0000;
//     READY=0 for exactly 2 cycles; INSTRET unchanged.
//  5. TIMER=1 with WB_EXC=0x10 (LAM): CAUSE=0x8000_0000_0000_0007, no writes.
//  6. Reset asserted in the 1st flush cycle: next cycle READY=1, FLUSH=0.
//     With CNT_W=4 and INSTRET at 15, one retire gives INSTRET=0.

Source files
------------

// File: rtl/writeback_retire.sv
// ---------------------------------------------------------------------------
// writeback_retire
//
// Writeback / retire stage. For every accepted instruction it chooses the
// register-file and CSR write data, resolves exceptions and interrupts by
// priority and, on a trap, issues the redirect to the trap vector. After a
// trap it stalls upstream for a fixed flush window. It also counts retired
// instructions.
//
// Ports
//   CLK, RESET        clock, synchronous active-low reset
//   WB_V / WB_READY   valid / ready handshake (accept = WB_V & WB_READY)
//   WB_IR             instruction word; opcode [6:0], rd [11:7], funct3 [14:12]
//   WB_NPC            link value (PC+4)
//   WB_ALU_RESULT     ALU result, also the branch/jump target
//   WB_MEM_RESULT     load data
//   WB_RFD / WB_CSRFD old CSR value for rd / new CSR value
//   WB_PC_MUX         branch/jump taken
//   WB_EXC            {SAF,LAF,SAM,LAM,ECALL,II,IAF,IAM}
//   TIMER, EXTERNAL   level interrupt requests
//   PRIVILEGE         current privilege (0=U, 1=S, 3=M)
//   TVEC              trap vector base
//   WB_RF_DATA, WB_DRID_OUT, WB_ST_REG      register-file write port
//   WB_CSR_DATA, WB_ST_CSR                  CSR write port
//   WB_BR_JMP_TARGET, WB_PC_MUX_OUT         fetch redirect
//   WB_IR_OUT                               registered instruction word
//   WB_CAUSE, WB_CS                         trap cause and trap strobe
//   WB_FLUSH                                high during the flush window
//   WB_INSTRET                              retired-instruction counter
// ---------------------------------------------------------------------------
module writeback_retire #(
  parameter int XLEN         = 64,  // >= 8
  parameter int ILEN         = 32,
  parameter int FLUSH_CYCLES = 2,   // 1..15
  parameter int CNT_W        = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WB_V,
  output logic             WB_READY,
  input  logic [ILEN-1:0]  WB_IR,
  input  logic [XLEN-1:0]  WB_NPC,
  input  logic [XLEN-1:0]  WB_ALU_RESULT,
  input  logic [XLEN-1:0]  WB_MEM_RESULT,
  input  logic [XLEN-1:0]  WB_RFD,
  input  logic [XLEN-1:0]  WB_CSRFD,
  input  logic             WB_PC_MUX,
  input  logic [7:0]       WB_EXC,
  input  logic             TIMER,
  input  logic             EXTERNAL,
  input  logic [1:0]       PRIVILEGE,
  input  logic [XLEN-1:0]  TVEC,
  output logic [XLEN-1:0]  WB_RF_DATA,
  output logic [4:0]       WB_DRID_OUT,
  output logic             WB_ST_REG,
  output logic [XLEN-1:0]  WB_CSR_DATA,
  output logic             WB_ST_CSR,
  output logic [XLEN-1:0]  WB_BR_JMP_TARGET,
  output logic             WB_PC_MUX_OUT,
  output logic [ILEN-1:0]  WB_IR_OUT,
  output logic [XLEN-1:0]  WB_CAUSE,
  output logic             WB_CS,
  output logic             WB_FLUSH,
  output logic [CNT_W-1:0] WB_INSTRET
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Opcodes whose rd value comes from the ALU: OP-IMM, OP, OP-IMM-32,
  // OP-32, LUI, AUIPC.
  localparam int         N_ALU_OPS = 6;
  localparam logic [6:0] ALU_OPS [N_ALU_OPS] = '{
    7'b0010011, 7'b0110011, 7'b0011011,
    7'b0111011, 7'b0110111, 7'b0010111
  };

  // Exception cause codes indexed by WB_EXC bit position. Bit order is
  // also the priority order (bit 0 highest). The ECALL entry is replaced
  // by 8 + PRIVILEGE below.
  localparam logic [3:0] EXC_CODE [8] = '{
    4'd0,  // IAM
    4'd1,  // IAF
    4'd2,  // II
    4'd8,  // ECALL (privilege-dependent)
    4'd4,  // LAM
    4'd6,  // SAM
    4'd5,  // LAF
    4'd7   // SAF
  };
  localparam int         EXC_ECALL_BIT = 3;

  localparam logic [3:0] CAUSE_MEI = 4'd11;  // machine external interrupt
  localparam logic [3:0] CAUSE_MTI = 4'd7;   // machine timer interrupt

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  // -------------------------------------------------------------------------
  // Control FSM: RUN accepts instructions, FLUSH blocks for FLUSH_CYCLES
  // -------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] flush_cnt_reg, flush_cnt_next;

  logic accept;
  logic trap_take;

  assign accept = WB_V & WB_READY;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    WB_READY       = 1'b1;
    WB_FLUSH       = 1'b0;
    case (state_reg)
      ST_RUN: begin
        // READY is 1 in RUN, so WB_V alone is the accept here.
        if (WB_V && trap_take) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        WB_READY       = 1'b0;
        WB_FLUSH       = 1'b1;
        flush_cnt_next = flush_cnt_reg - 4'd1;
        // Counter was loaded with FLUSH_CYCLES on the trap edge, so leaving
        // when it reads 1 keeps READY low for exactly FLUSH_CYCLES cycles.
        if (flush_cnt_reg <= 4'd1) begin
          state_next     = ST_RUN;
          flush_cnt_next = 4'd0;
        end
      end
      default: begin
        state_next     = ST_RUN;
        flush_cnt_next = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Exception priority: a prefix-OR chain marks the lowest set WB_EXC bit
  // -------------------------------------------------------------------------
  logic [8:0] exc_seen;
  logic [7:0] exc_win;
  logic [3:0] exc_code_masked [8];
  logic [3:0] exc_code;

  assign exc_seen[0] = 1'b0;

  for (genvar gi = 0; gi < 8; gi++) begin : g_exc_prio
    assign exc_seen[gi+1] = exc_seen[gi] | WB_EXC[gi];
    assign exc_win[gi]    = WB_EXC[gi] & ~exc_seen[gi];
    if (gi == EXC_ECALL_BIT) begin : g_ecall
      // Environment call from U/S/M maps to 8/9/11.
      assign exc_code_masked[gi] = exc_win[gi] ? {2'b10, PRIVILEGE} : 4'd0;
    end else begin : g_fixed
      assign exc_code_masked[gi] = exc_win[gi] ? EXC_CODE[gi] : 4'd0;
    end
  end

  // At most one exc_win bit is set, so OR-ing the masked codes selects it.
  always_comb begin
    exc_code = 4'd0;
    for (int i = 0; i < 8; i++) begin
      exc_code = exc_code | exc_code_masked[i];
    end
  end

  // -------------------------------------------------------------------------
  // Trap resolution: interrupts outrank every synchronous exception
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] trap_cause;

  assign trap_take = EXTERNAL | TIMER | (|WB_EXC);

  always_comb begin
    trap_cause = '0;
    if (EXTERNAL) begin
      trap_cause[XLEN-1] = 1'b1;
      trap_cause[3:0]    = CAUSE_MEI;
    end else if (TIMER) begin
      trap_cause[XLEN-1] = 1'b1;
      trap_cause[3:0]    = CAUSE_MTI;
    end else begin
      trap_cause[3:0]    = exc_code;
    end
  end

  // -------------------------------------------------------------------------
  // Destination-data decode
  // -------------------------------------------------------------------------
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [4:0]           rd;
  logic [N_ALU_OPS-1:0] alu_hit;
  logic                 rd_wr_en;
  logic                 is_csr;
  logic [XLEN-1:0]      rd_wdata;

  assign opcode = WB_IR[6:0];
  assign funct3 = WB_IR[14:12];
  assign rd     = WB_IR[11:7];

  for (genvar gi = 0; gi < N_ALU_OPS; gi++) begin : g_alu_op
    assign alu_hit[gi] = (opcode == ALU_OPS[gi]);
  end

  always_comb begin
    rd_wr_en = 1'b0;
    is_csr   = 1'b0;
    rd_wdata = '0;
    if (opcode == OP_LOAD) begin
      rd_wr_en = 1'b1;
      rd_wdata = WB_MEM_RESULT;
    end else if (|alu_hit) begin
      rd_wr_en = 1'b1;
      rd_wdata = WB_ALU_RESULT;
    end else if (opcode == OP_JAL || opcode == OP_JALR) begin
      rd_wr_en = 1'b1;
      rd_wdata = WB_NPC;
    end else if (opcode == OP_SYSTEM && funct3 != 3'd0) begin
      // CSR instructions; funct3 == 0 is ECALL/EBREAK/xRET and writes nothing.
      rd_wr_en = 1'b1;
      is_csr   = 1'b1;
      rd_wdata = WB_RFD;
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs. Strobes default low every cycle; data registers
  // only change on an accept and otherwise hold.
  // -------------------------------------------------------------------------
  logic [XLEN-1:0]  rf_data_reg;
  logic [4:0]       drid_reg;
  logic             st_reg_reg;
  logic [XLEN-1:0]  csr_data_reg;
  logic             st_csr_reg;
  logic [XLEN-1:0]  target_reg;
  logic             pc_mux_out_reg;
  logic [ILEN-1:0]  ir_out_reg;
  logic [XLEN-1:0]  cause_reg;
  logic             cs_reg;
  logic [CNT_W-1:0] instret_reg;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rf_data_reg    <= '0;
      drid_reg       <= '0;
      st_reg_reg     <= 1'b0;
      csr_data_reg   <= '0;
      st_csr_reg     <= 1'b0;
      target_reg     <= '0;
      pc_mux_out_reg <= 1'b0;
      ir_out_reg     <= '0;
      cause_reg      <= '0;
      cs_reg         <= 1'b0;
      instret_reg    <= '0;
    end else begin
      st_reg_reg     <= 1'b0;
      st_csr_reg     <= 1'b0;
      pc_mux_out_reg <= 1'b0;
      cs_reg         <= 1'b0;
      if (accept) begin
        ir_out_reg <= WB_IR;
        drid_reg   <= rd;
        if (trap_take) begin
          // Trapping instruction does not retire and writes nothing.
          cs_reg         <= 1'b1;
          cause_reg      <= trap_cause;
          pc_mux_out_reg <= 1'b1;
          target_reg     <= TVEC;
        end else begin
          pc_mux_out_reg <= WB_PC_MUX;
          target_reg     <= WB_ALU_RESULT;
          instret_reg    <= instret_reg + CNT_W'(1);
          if (rd_wr_en) begin
            rf_data_reg <= rd_wdata;
            st_reg_reg  <= (rd != 5'd0);
          end
          if (is_csr) begin
            csr_data_reg <= WB_CSRFD;
            st_csr_reg   <= 1'b1;
          end
        end
      end
    end
  end

  assign WB_RF_DATA       = rf_data_reg;
  assign WB_DRID_OUT      = drid_reg;
  assign WB_ST_REG        = st_reg_reg;
  assign WB_CSR_DATA      = csr_data_reg;
  assign WB_ST_CSR        = st_csr_reg;
  assign WB_BR_JMP_TARGET = target_reg;
  assign WB_PC_MUX_OUT    = pc_mux_out_reg;
  assign WB_IR_OUT        = ir_out_reg;
  assign WB_CAUSE         = cause_reg;
  assign WB_CS            = cs_reg;
  assign WB_INSTRET       = instret_reg;

endmodule

// File: tb/tb_writeback_retire.sv
// ---------------------------------------------------------------------------
// tb_writeback_retire
//
// Bench for writeback_retire. Two instances share all inputs: one with a
// 64-bit retire counter and one with a 4-bit counter for wrap-around.
// A behavioural model predicts every output on every clock; a table of
// directed vectors adds hand-computed expectations, followed by multi-cycle
// sequences and a randomized phase.
// ---------------------------------------------------------------------------
module tb_writeback_retire;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int FC   = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs
  logic            RESET;
  logic            WB_V;
  logic [ILEN-1:0] WB_IR;
  logic [XLEN-1:0] WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_RFD, WB_CSRFD, TVEC;
  logic            WB_PC_MUX;
  logic [7:0]      WB_EXC;
  logic            TIMER, EXTERNAL;
  logic [1:0]      PRIVILEGE;

  // Outputs, 64-bit-counter instance
  logic            WB_READY, WB_ST_REG, WB_ST_CSR, WB_PC_MUX_OUT, WB_CS, WB_FLUSH;
  logic [XLEN-1:0] WB_RF_DATA, WB_CSR_DATA, WB_BR_JMP_TARGET, WB_CAUSE;
  logic [4:0]      WB_DRID_OUT;
  logic [ILEN-1:0] WB_IR_OUT;
  logic [63:0]     WB_INSTRET;

  // Outputs, 4-bit-counter instance
  logic            b_ready, b_st_reg, b_st_csr, b_pcm, b_cs, b_flush;
  logic [XLEN-1:0] b_rf, b_csr, b_target, b_cause;
  logic [4:0]      b_drid;
  logic [ILEN-1:0] b_ir;
  logic [3:0]      b_instret;

  writeback_retire #(.XLEN(XLEN), .ILEN(ILEN), .FLUSH_CYCLES(FC), .CNT_W(64)) dut (
    .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_READY(WB_READY), .WB_IR(WB_IR),
    .WB_NPC(WB_NPC), .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT),
    .WB_RFD(WB_RFD), .WB_CSRFD(WB_CSRFD), .WB_PC_MUX(WB_PC_MUX), .WB_EXC(WB_EXC),
    .TIMER(TIMER), .EXTERNAL(EXTERNAL), .PRIVILEGE(PRIVILEGE), .TVEC(TVEC),
    .WB_RF_DATA(WB_RF_DATA), .WB_DRID_OUT(WB_DRID_OUT), .WB_ST_REG(WB_ST_REG),
    .WB_CSR_DATA(WB_CSR_DATA), .WB_ST_CSR(WB_ST_CSR), .WB_BR_JMP_TARGET(WB_BR_JMP_TARGET),
    .WB_PC_MUX_OUT(WB_PC_MUX_OUT), .WB_IR_OUT(WB_IR_OUT), .WB_CAUSE(WB_CAUSE),
    .WB_CS(WB_CS), .WB_FLUSH(WB_FLUSH), .WB_INSTRET(WB_INSTRET)
  );

  writeback_retire #(.XLEN(XLEN), .ILEN(ILEN), .FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_READY(b_ready), .WB_IR(WB_IR),
    .WB_NPC(WB_NPC), .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT),
    .WB_RFD(WB_RFD), .WB_CSRFD(WB_CSRFD), .WB_PC_MUX(WB_PC_MUX), .WB_EXC(WB_EXC),
    .TIMER(TIMER), .EXTERNAL(EXTERNAL), .PRIVILEGE(PRIVILEGE), .TVEC(TVEC),
    .WB_RF_DATA(b_rf), .WB_DRID_OUT(b_drid), .WB_ST_REG(b_st_reg),
    .WB_CSR_DATA(b_csr), .WB_ST_CSR(b_st_csr), .WB_BR_JMP_TARGET(b_target),
    .WB_PC_MUX_OUT(b_pcm), .WB_IR_OUT(b_ir), .WB_CAUSE(b_cause),
    .WB_CS(b_cs), .WB_FLUSH(b_flush), .WB_INSTRET(b_instret)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: "stall cycles left" count plus the visible outputs
  // -------------------------------------------------------------------------
  int          m_left;
  logic [63:0] m_rf, m_csr, m_target, m_cause, m_instret;
  logic [4:0]  m_drid;
  logic [31:0] m_ir;
  logic        m_st_reg, m_st_csr, m_pcm, m_cs;

  // Returns whether the presented instruction traps and with what cause.
  task automatic trap_lookup(output logic hit, output logic [63:0] cause);
    logic [3:0] code [8];
    code = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd4, 4'd6, 4'd5, 4'd7};
    hit   = 1'b1;
    cause = 64'd0;
    if (EXTERNAL)   cause = 64'h8000_0000_0000_000B;
    else if (TIMER) cause = 64'h8000_0000_0000_0007;
    else begin
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (!hit && WB_EXC[i]) begin
          hit   = 1'b1;
          cause = (i == 3) ? 64'(8 + int'(PRIVILEGE)) : 64'(code[i]);
        end
      end
    end
  endtask

  // Advances the model by one rising edge using the inputs now applied.
  task automatic model_edge();
    logic        hit, wr, csr;
    logic [63:0] cause, val;
    if (!RESET) begin
      m_left = 0; m_rf = 0; m_csr = 0; m_target = 0; m_cause = 0; m_instret = 0;
      m_drid = 0; m_ir = 0; m_st_reg = 0; m_st_csr = 0; m_pcm = 0; m_cs = 0;
      return;
    end
    m_st_reg = 0; m_st_csr = 0; m_pcm = 0; m_cs = 0;
    if (m_left > 0) begin
      m_left--;
    end else if (WB_V) begin
      m_ir   = WB_IR;
      m_drid = WB_IR[11:7];
      trap_lookup(hit, cause);
      if (hit) begin
        m_cs = 1; m_cause = cause; m_pcm = 1; m_target = TVEC; m_left = FC;
      end else begin
        m_pcm = WB_PC_MUX; m_target = WB_ALU_RESULT; m_instret = m_instret + 1;
        wr = 0; csr = 0; val = 0;
        case (WB_IR[6:0])
          7'b0000011: begin wr = 1; val = WB_MEM_RESULT; end
          7'b0010011, 7'b0110011, 7'b0011011,
          7'b0111011, 7'b0110111, 7'b0010111: begin wr = 1; val = WB_ALU_RESULT; end
          7'b1101111, 7'b1100111: begin wr = 1; val = WB_NPC; end
          7'b1110011: if (WB_IR[14:12] != 3'd0) begin wr = 1; csr = 1; val = WB_RFD; end
          default: ;
        endcase
        if (wr) begin m_rf = val; m_st_reg = (WB_IR[11:7] != 5'd0); end
        if (csr) begin m_csr = WB_CSRFD; m_st_csr = 1; end
      end
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".ready"},   WB_READY,         64'(m_left == 0));
    chk({t, ".flush"},   WB_FLUSH,         64'(m_left != 0));
    chk({t, ".rf"},      WB_RF_DATA,       m_rf);
    chk({t, ".drid"},    WB_DRID_OUT,      64'(m_drid));
    chk({t, ".st_reg"},  WB_ST_REG,        64'(m_st_reg));
    chk({t, ".csr"},     WB_CSR_DATA,      m_csr);
    chk({t, ".st_csr"},  WB_ST_CSR,        64'(m_st_csr));
    chk({t, ".target"},  WB_BR_JMP_TARGET, m_target);
    chk({t, ".pcm"},     WB_PC_MUX_OUT,    64'(m_pcm));
    chk({t, ".ir"},      WB_IR_OUT,        64'(m_ir));
    chk({t, ".cause"},   WB_CAUSE,         m_cause);
    chk({t, ".cs"},      WB_CS,            64'(m_cs));
    chk({t, ".instret"}, WB_INSTRET,       m_instret);
    chk({t, ".b.ready"}, b_ready,  64'(m_left == 0));
    chk({t, ".b.flush"}, b_flush,  64'(m_left != 0));
    chk({t, ".b.wr"},    {b_st_reg, b_st_csr, b_pcm, b_cs}, {60'd0, m_st_reg, m_st_csr, m_pcm, m_cs});
    chk({t, ".b.data"},  b_rf ^ b_csr ^ b_target ^ b_cause, m_rf ^ m_csr ^ m_target ^ m_cause);
    chk({t, ".b.ir"},    {b_ir, b_drid}, {m_ir, m_drid});
    chk({t, ".b.instret"}, b_instret, 64'(m_instret[3:0]));
  endtask

  task automatic tick(input string t);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(t);
  endtask

  task automatic wait_ready(input string t);
    for (int k = 0; k < 16 && WB_READY !== 1'b1; k++) tick({t, ".wait"});
    chk({t, ".ready_bound"}, WB_READY, 64'd1);
  endtask

  // -------------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic [31:0] ir;
    logic [63:0] npc, alu, mem, rfd, csrfd, tvec;
    logic        pcmux, timer, ext;
    logic [7:0]  exc;
    logic [1:0]  priv;
    logic        e_st_reg, e_st_csr, e_pcm, e_cs, e_retire;
    logic [63:0] e_cause, e_target, e_rf, e_csr;
  } vec_t;

  vec_t        tv[$];
  logic [63:0] tbl_ret;

  function automatic vec_t blank();
    vec_t v;
    v.ir = 32'h0000_0013; v.npc = 64'h104; v.alu = 64'h1234; v.mem = 64'hCAFE;
    v.rfd = 64'h11; v.csrfd = 64'h22; v.tvec = 64'h8000_0000;
    v.pcmux = 0; v.timer = 0; v.ext = 0; v.exc = 8'h00; v.priv = 2'd3;
    v.e_st_reg = 0; v.e_st_csr = 0; v.e_pcm = 0; v.e_cs = 0; v.e_retire = 1;
    v.e_cause = 0; v.e_target = 64'h1234; v.e_rf = 0; v.e_csr = 0;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    WB_IR = v.ir; WB_NPC = v.npc; WB_ALU_RESULT = v.alu; WB_MEM_RESULT = v.mem;
    WB_RFD = v.rfd; WB_CSRFD = v.csrfd; TVEC = v.tvec; WB_PC_MUX = v.pcmux;
    TIMER = v.timer; EXTERNAL = v.ext; WB_EXC = v.exc; PRIVILEGE = v.priv; WB_V = 1;
    tick(t);
    chk({t, ".t_st_reg"}, WB_ST_REG,        64'(v.e_st_reg));
    chk({t, ".t_st_csr"}, WB_ST_CSR,        64'(v.e_st_csr));
    chk({t, ".t_pcm"},    WB_PC_MUX_OUT,    64'(v.e_pcm));
    chk({t, ".t_cs"},     WB_CS,            64'(v.e_cs));
    chk({t, ".t_target"}, WB_BR_JMP_TARGET, v.e_target);
    chk({t, ".t_drid"},   WB_DRID_OUT,      64'(v.ir[11:7]));
    if (v.e_cs)     chk({t, ".t_cause"}, WB_CAUSE,    v.e_cause);
    if (v.e_st_reg) chk({t, ".t_rf"},    WB_RF_DATA,  v.e_rf);
    if (v.e_st_csr) chk({t, ".t_csr"},   WB_CSR_DATA, v.e_csr);
    tbl_ret = tbl_ret + 64'(v.e_retire);
    chk({t, ".t_instret"}, WB_INSTRET, tbl_ret);
    $display("%s ir=%h exc=%h tmr=%0d ext=%0d -> st_reg=%0d st_csr=%0d cs=%0d cause=%h target=%h",
             t, v.ir, v.exc, v.timer, v.ext, WB_ST_REG, WB_ST_CSR, WB_CS, WB_CAUSE, WB_BR_JMP_TARGET);
    WB_V = 0; WB_EXC = 0; TIMER = 0; EXTERNAL = 0;
    tick({t, ".idle"});
    chk({t, ".strobes_drop"}, {WB_ST_REG, WB_ST_CSR, WB_PC_MUX_OUT, WB_CS}, 64'd0);
    wait_ready(t);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [6:0]  rnd_ops [13];
  logic [63:0] ret_before;
  int          low;

  initial begin
    vec_t v;
    RESET = 0; WB_V = 0; WB_IR = 0; WB_NPC = 0; WB_ALU_RESULT = 0; WB_MEM_RESULT = 0;
    WB_RFD = 0; WB_CSRFD = 0; TVEC = 0; WB_PC_MUX = 0; WB_EXC = 0; TIMER = 0;
    EXTERNAL = 0; PRIVILEGE = 0;
    m_left = 0; m_rf = 0; m_csr = 0; m_target = 0; m_cause = 0; m_instret = 0;
    m_drid = 0; m_ir = 0; m_st_reg = 0; m_st_csr = 0; m_pcm = 0; m_cs = 0;

    // Reset held low for two cycles.
    tick("reset0");
    tick("reset1");
    chk("reset.ready",   WB_READY,   64'd1);
    chk("reset.instret", WB_INSTRET, 64'd0);
    chk("reset.outs", WB_RF_DATA | WB_CSR_DATA | WB_BR_JMP_TARGET | WB_CAUSE, 64'd0);
    $display("reset: ready=%0d flush=%0d instret=%0d", WB_READY, WB_FLUSH, WB_INSTRET);
    RESET = 1;

    // Table: ADDI x5
    v = blank(); v.ir = 32'h00A2_8293; v.e_st_reg = 1; v.e_rf = 64'h1234; tv.push_back(v);
    // JAL x0 with taken redirect
    v = blank(); v.ir = 32'h0000_006F; v.alu = 64'h200; v.pcmux = 1;
    v.e_pcm = 1; v.e_target = 64'h200; tv.push_back(v);
    // ECALL from M
    v = blank(); v.ir = 32'h0000_0073; v.exc = 8'h08; v.e_retire = 0; v.e_cs = 1;
    v.e_pcm = 1; v.e_cause = 64'd11; v.e_target = 64'h8000_0000; tv.push_back(v);
    // TIMER beats LAM on a load
    v = blank(); v.ir = 32'h0002_B303; v.exc = 8'h10; v.timer = 1; v.e_retire = 0; v.e_cs = 1;
    v.e_pcm = 1; v.e_cause = 64'h8000_0000_0000_0007; v.e_target = 64'h8000_0000; tv.push_back(v);
    // LW x6
    v = blank(); v.ir = 32'h0002_A303; v.e_st_reg = 1; v.e_rf = 64'hCAFE; tv.push_back(v);
    // JALR x1 links NPC
    v = blank(); v.ir = 32'h0000_80E7; v.npc = 64'h3000; v.alu = 64'h4000; v.pcmux = 1;
    v.e_st_reg = 1; v.e_rf = 64'h3000; v.e_pcm = 1; v.e_target = 64'h4000; tv.push_back(v);
    // CSRRW x7, mstatus
    v = blank(); v.ir = 32'h3000_13F3; v.e_st_reg = 1; v.e_rf = 64'h11;
    v.e_st_csr = 1; v.e_csr = 64'h22; tv.push_back(v);
    // EXTERNAL beats TIMER and IAM
    v = blank(); v.exc = 8'h01; v.timer = 1; v.ext = 1; v.e_retire = 0; v.e_cs = 1;
    v.e_pcm = 1; v.e_cause = 64'h8000_0000_0000_000B; v.e_target = 64'h8000_0000; tv.push_back(v);
    // IAF beats II
    v = blank(); v.exc = 8'h06; v.e_retire = 0; v.e_cs = 1; v.e_pcm = 1;
    v.e_cause = 64'd1; v.e_target = 64'h8000_0000; tv.push_back(v);
    // LAF beats SAF
    v = blank(); v.exc = 8'hC0; v.e_retire = 0; v.e_cs = 1; v.e_pcm = 1;
    v.e_cause = 64'd5; v.e_target = 64'h8000_0000; tv.push_back(v);
    // SAM beats LAF
    v = blank(); v.exc = 8'h60; v.e_retire = 0; v.e_cs = 1; v.e_pcm = 1;
    v.e_cause = 64'd6; v.e_target = 64'h8000_0000; tv.push_back(v);
    // ECALL from U beats LAM
    v = blank(); v.ir = 32'h0000_0073; v.exc = 8'h18; v.priv = 2'd0; v.e_retire = 0;
    v.e_cs = 1; v.e_pcm = 1; v.e_cause = 64'd8; v.e_target = 64'h8000_0000; tv.push_back(v);
    // ECALL from S
    v = blank(); v.ir = 32'h0000_0073; v.exc = 8'h08; v.priv = 2'd1; v.e_retire = 0;
    v.e_cs = 1; v.e_pcm = 1; v.e_cause = 64'd9; v.e_target = 64'h8000_0000; tv.push_back(v);
    // SAF alone
    v = blank(); v.exc = 8'h80; v.tvec = 64'h0000_0000_0000_0400; v.e_retire = 0; v.e_cs = 1;
    v.e_pcm = 1; v.e_cause = 64'd7; v.e_target = 64'h400; tv.push_back(v);
    // Store with non-zero [11:7]: no register write
    v = blank(); v.ir = 32'h0062_A423; tv.push_back(v);
    // ADD x0: retires, no strobe
    v = blank(); v.ir = 32'h0000_0033; tv.push_back(v);
    // EBREAK encoding without exception: SYSTEM funct3=0 writes nothing
    v = blank(); v.ir = 32'h0010_0073; tv.push_back(v);

    tbl_ret = 64'd0;
    foreach (tv[i]) apply_vec(tv[i], i);

    // ECALL: READY low for exactly FC cycles while upstream keeps WB_V high.
    ret_before = m_instret;
    WB_IR = 32'h0000_0073; WB_EXC = 8'h08; PRIVILEGE = 2'd3; TVEC = 64'h8000_0000; WB_V = 1;
    tick("ecall");
    chk("ecall.cause", WB_CAUSE, 64'd11);
    WB_EXC = 0; WB_IR = 32'h00A2_8293;
    low = 0;
    for (int k = 0; k < 10 && WB_READY === 1'b0; k++) begin
      low++;
      tick("ecall.flush");
    end
    chk("ecall.flush_len", 64'(low), 64'(FC));
    WB_V = 0;
    tick("ecall.after");
    chk("ecall.instret", WB_INSTRET, ret_before);
    $display("ecall: flush cycles=%0d instret=%0d", low, WB_INSTRET);

    // Reset during the first flush cycle.
    WB_IR = 32'h0000_0073; WB_EXC = 8'h08; WB_V = 1;
    tick("rstflush.trap");
    WB_V = 0; WB_EXC = 0; RESET = 0;
    tick("rstflush.reset");
    chk("rstflush.ready", WB_READY, 64'd1);
    chk("rstflush.flush", WB_FLUSH, 64'd0);
    $display("reset mid-flush: ready=%0d flush=%0d", WB_READY, WB_FLUSH);
    RESET = 1;

    // Retire counter wrap on the 4-bit instance.
    WB_IR = 32'h00A2_8293; WB_V = 1;
    for (int k = 0; k < 15; k++) tick("wrap.fill");
    chk("wrap.at15", b_instret, 64'd15);
    tick("wrap.step");
    chk("wrap.to0",  b_instret,  64'd0);
    chk("wrap.wide", WB_INSTRET, 64'd16);
    $display("wrap: cnt4=%0d cnt64=%0d", b_instret, WB_INSTRET);
    WB_V = 0;
    tick("wrap.idle");

    // Randomized phase.
    rnd_ops = '{7'b0000011, 7'b0010011, 7'b0110011, 7'b0011011, 7'b0111011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011,
                7'b0100011, 7'b1100011, 7'b0001111};
    for (int n = 0; n < 400; n++) begin
      RESET         = ($urandom_range(0, 59) != 0);
      WB_V          = ($urandom_range(0, 3) != 0);
      WB_IR         = $urandom;
      WB_IR[6:0]    = ($urandom_range(0, 15) == 0) ? 7'($urandom) : rnd_ops[$urandom_range(0, 12)];
      WB_NPC        = {$urandom, $urandom};
      WB_ALU_RESULT = {$urandom, $urandom};
      WB_MEM_RESULT = {$urandom, $urandom};
      WB_RFD        = {$urandom, $urandom};
      WB_CSRFD      = {$urandom, $urandom};
      TVEC          = {$urandom, $urandom};
      WB_PC_MUX     = 1'($urandom);
      WB_EXC        = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
      TIMER         = ($urandom_range(0, 9) == 0);
      EXTERNAL      = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 2))
        0:       PRIVILEGE = 2'd0;
        1:       PRIVILEGE = 2'd1;
        default: PRIVILEGE = 2'd3;
      endcase
      tick($sformatf("rnd%0d", n));
    end
    $display("random: 400 cycles, model instret=%0d", m_instret);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
